// File: rtl/pipe_flow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and defaults for the pipeline PC-flow / hazard sequencer.
//   pipe_state_e  : sequencer states (RUN, SQUASH, HALTED)
//   DEF_PC_W      : default program counter width
//   DEF_FLUSH_CYC : default number of squash cycles after a redirect (1..7)
//   DEF_CNT_W     : default performance counter width
//   PC_STEP       : sequential PC increment in bytes
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  localparam int DEF_PC_W      = 9;
  localparam int DEF_FLUSH_CYC = 2;
  localparam int DEF_CNT_W     = 16;
  localparam int PC_STEP       = 4;

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_flow_ctrl_if
// Bundle between the branch unit / hazard detector, the sequencer and the
// PC / pipeline registers.
//   Inputs to sequencer : ex_valid, ex_redirect, ex_target[31:0], ex_halt,
//                         ex_pc[PC_W-1:0], id_load_use, resume
//   Outputs of sequencer: pc_write, pc_load, pc_target[PC_W-1:0],
//                         if_id_flush, id_ex_flush, if_id_hold, halted,
//                         redirect_cnt[CNT_W-1:0], stall_cnt[CNT_W-1:0]
//   master : the pipeline side (drives EX/ID status, consumes controls)
//   slave  : the sequencer side
// ---------------------------------------------------------------------------
interface pipe_flow_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             ex_valid;
  logic             ex_redirect;
  logic [31:0]      ex_target;
  logic             ex_halt;
  logic [PC_W-1:0]  ex_pc;
  logic             id_load_use;
  logic             resume;

  logic             pc_write;
  logic             pc_load;
  logic [PC_W-1:0]  pc_target;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             if_id_hold;
  logic             halted;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ex_valid, ex_redirect, ex_target, ex_halt, ex_pc, id_load_use, resume,
    input  pc_write, pc_load, pc_target, if_id_flush, id_ex_flush, if_id_hold,
           halted, redirect_cnt, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_redirect, ex_target, ex_halt, ex_pc, id_load_use, resume,
    output pc_write, pc_load, pc_target, if_id_flush, id_ex_flush, if_id_hold,
           halted, redirect_cnt, stall_cnt
  );

endinterface

// File: rtl/pipe_flow_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter, cleared only by reset.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_flow_ctrl
// PC-flow and hazard sequencer for the 5-stage pipeline. Turns EX branch
// resolution, halts and ID load-use hazards into PC enable/load and
// IF/ID, ID/EX flush/hold controls, and runs the halt/resume sequence.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset (all outputs forced to 0)
//   bus   : pipe_flow_ctrl_if.slave (EX/ID status in, controls out)
// Parameters: PC_W, FLUSH_CYC (1..7), CNT_W.
// Build option: define PIPE_PERF_CNT_EN to instantiate the saturating
// redirect / stall counters; otherwise both counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module pipe_flow_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst_n,
  pipe_flow_ctrl_if.slave bus
);

  localparam logic [2:0]      SQ_INIT = 3'(FLUSH_CYC - 1);
  localparam logic [PC_W-1:0] STEP    = PC_W'(PC_STEP);

  pipe_state_e     state;
  logic [2:0]      squash_cnt;
  logic [PC_W-1:0] halt_pc;

  logic halt_req;
  logic redir_req;

  logic            pc_write_c;
  logic            pc_load_c;
  logic [PC_W-1:0] pc_target_c;
  logic            if_id_flush_c;
  logic            id_ex_flush_c;
  logic            if_id_hold_c;
  logic            halted_c;

  // Bits outside the PC window and the alignment bits of the target are dropped.
  logic target_unused;
  assign target_unused = ^{bus.ex_target[31:PC_W], bus.ex_target[1:0]};

  assign halt_req  = bus.ex_valid & bus.ex_halt;
  assign redir_req = bus.ex_valid & bus.ex_redirect;

  // State register: halt beats redirect; squash length counts the redirect
  // cycle itself, so SQUASH lasts FLUSH_CYC-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      squash_cnt <= '0;
      halt_pc    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            halt_pc <= bus.ex_pc;
            state   <= HALTED;
          end else if (redir_req && (FLUSH_CYC > 1)) begin
            squash_cnt <= SQ_INIT;
            state      <= SQUASH;
          end
        end
        SQUASH: begin
          if (squash_cnt <= 3'd1) begin
            squash_cnt <= '0;
            state      <= RUN;
          end else begin
            squash_cnt <= squash_cnt - 3'd1;
          end
        end
        HALTED: begin
          if (bus.resume) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Control outputs decode from state plus live inputs; reset forces them low.
  always_comb begin
    pc_write_c    = 1'b0;
    pc_load_c     = 1'b0;
    pc_target_c   = '0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    if_id_hold_c  = 1'b0;
    halted_c      = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (halt_req) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (redir_req) begin
            pc_write_c    = 1'b1;
            pc_load_c     = 1'b1;
            pc_target_c   = {bus.ex_target[PC_W-1:2], 2'b00};
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (bus.id_load_use) begin
            if_id_hold_c  = 1'b1;
            id_ex_flush_c = 1'b1;
          end else begin
            pc_write_c = 1'b1;
          end
        end
        SQUASH: begin
          pc_write_c    = 1'b1;
          id_ex_flush_c = 1'b1;
        end
        HALTED: begin
          halted_c      = 1'b1;
          id_ex_flush_c = 1'b1;
          if (bus.resume) begin
            pc_write_c    = 1'b1;
            pc_load_c     = 1'b1;
            pc_target_c   = halt_pc + STEP;
            if_id_flush_c = 1'b1;
          end else begin
            if_id_hold_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.pc_load     = pc_load_c;
  assign bus.pc_target   = pc_target_c;
  assign bus.if_id_flush = if_id_flush_c;
  assign bus.id_ex_flush = id_ex_flush_c;
  assign bus.if_id_hold  = if_id_hold_c;
  assign bus.halted      = halted_c;

`ifdef PIPE_PERF_CNT_EN
  logic             accept_redirect;
  logic             stall_cyc;
  logic [CNT_W-1:0] redirect_q;
  logic [CNT_W-1:0] stall_q;

  // Only redirects and stalls actually honoured in RUN are counted.
  assign accept_redirect = (state == RUN) & ~halt_req & redir_req;
  assign stall_cyc       = (state == RUN) & ~halt_req & ~redir_req & bus.id_load_use;

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept_redirect),
    .count (redirect_q)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_cyc),
    .count (stall_q)
  );

  assign bus.redirect_cnt = redirect_q;
  assign bus.stall_cnt    = stall_q;
`else
  assign bus.redirect_cnt = '0;
  assign bus.stall_cnt    = '0;
`endif

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
Central PC-flow and hazard sequencer for the 5-stage pipeline. Consumes the EX-stage branch resolution (redirect request, target, halt) and the ID-stage load-use hazard flag. Drives PC write/load, the IF/ID and ID/EX flush/hold controls, and the halt/resume sequence. It sits between the branch unit / hazard detector and the PC register and pipeline registers.

Parameters:
PC_W, 9, width of the program counter held in the PC register.
FLUSH_CYC, 2, number of cycles younger stages stay squashed after a redirect (1..7).
CNT_W, 16, width of the performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
ex_redirect  in  1  EX resolved a taken branch or jump (PC select from branch unit).
ex_target  in  32  redirect target from branch unit.
ex_halt  in  1  EX instruction is a halt.
ex_pc  in  PC_W  PC of the instruction in EX.
id_load_use  in  1  ID instruction depends on a load currently in EX.
resume  in  1  single-cycle restart pulse from debug/testbench.
pc_write  out  1  PC register enable.
pc_load  out  1  1: PC takes pc_target; 0: PC takes PC+4.
pc_target  out  PC_W  redirect/resume PC.
if_id_flush  out  1  clear IF/ID to a bubble.
id_ex_flush  out  1  clear ID/EX to a bubble.
if_id_hold  out  1  freeze IF/ID contents.
halted  out  1  core is halted.
redirect_cnt  out  CNT_W  taken redirects (feature-gated).
stall_cnt  out  CNT_W  load-use stall cycles (feature-gated).

Behaviour:
- Single clock and reset: clk, with asynchronous active-low reset on rst_n.
- While rst_n=0, all outputs are 0. Internal state is RUN; squash counter, halt_pc and counters are 0.
- State machine: RUN, SQUASH, HALTED. Outputs are combinational from the state and current inputs. State and registers update on the clk edge.
- RUN priority is halt > redirect > load-use. Inputs qualify only when ex_valid=1, except id_load_use, which qualifies alone.
- RUN, ex_halt:
  - pc_write=0, if_id_flush=1, id_ex_flush=1.
  - Capture halt_pc=ex_pc, then go to HALTED.
- RUN, ex_redirect:
  - pc_write=1, pc_load=1, if_id_flush=1, id_ex_flush=1.
  - pc_target = ex_target[PC_W-1:0] with bits [1:0] forced to 0. Upper target bits are silently dropped.
  - If FLUSH_CYC>1: load squash counter with FLUSH_CYC-1 and go to SQUASH. Otherwise stay in RUN.
  - A concurrent id_load_use is ignored, because the dependent instruction is being flushed.
- RUN, id_load_use only:
  - pc_write=0, if_id_hold=1, id_ex_flush=1, for one cycle per asserted cycle.
  - Stay in RUN.
- RUN, none of the above: pc_write=1, pc_load=0, all other controls 0.
- SQUASH:
  - pc_write=1, pc_load=0, id_ex_flush=1.
  - ex_valid, ex_redirect, ex_halt and id_load_use are ignored.
  - The counter decrements each cycle. Return to RUN in the cycle after it reaches 0.
- HALTED:
  - halted=1, pc_write=0, if_id_hold=1, id_ex_flush=1. All EX/ID inputs are ignored.
  - On resume=1, in the same cycle: pc_write=1, pc_load=1, pc_target=halt_pc+4 (modulo 2^PC_W, wrap-around allowed), if_id_flush=1, then go to RUN.
- resume outside HALTED has no effect.
- rst_n asserted mid-SQUASH or mid-HALTED returns immediately to the reset state. There is no pending resume or redirect memory.

Optional Feature:
PIPE_PERF_CNT_EN:
- Defined:
  - redirect_cnt increments on each accepted RUN redirect.
  - stall_cnt increments on each load-use stall cycle.
  - Both saturate at 2^CNT_W-1 and clear only on reset.
- Undefined: both ports are driven constant 0 and no counter flops are instantiated.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum type pipe_state_e (RUN, SQUASH, HALTED);
  - the default PC_W, FLUSH_CYC and CNT_W constants;
  - the localparam PC_STEP=4.
- One sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output count). It is instantiated twice under PIPE_PERF_CNT_EN.

Test Plan:
- Reset with rst_n=0 mid-cycle -> all outputs 0 asynchronously. After release with idle inputs: pc_write=1, pc_load=0.
- ex_valid=1, ex_redirect=1, ex_target=0x0000_0123, FLUSH_CYC=2:
  - same cycle: pc_load=1, pc_target=0x120, both flushes=1;
  - next cycle: id_ex_flush=1 with an injected ex_redirect ignored;
  - then back in RUN.
- id_load_use=1 for 2 cycles -> pc_write=0, if_id_hold=1, id_ex_flush=1 for exactly 2 cycles. stall_cnt=2 when PIPE_PERF_CNT_EN is defined.
- ex_valid=1 with ex_halt=1 and ex_redirect=1, ex_pc=0x1FC:
  - halt wins: halted=1, pc_write=0;
  - resume pulse after 5 cycles -> pc_load=1, pc_target=0x000 (wrap).
- ex_redirect=1 with ex_valid=0 -> no redirect; pc_write=1, pc_load=0.
- With PIPE_PERF_CNT_EN, CNT_W=2: 5 redirects -> redirect_cnt saturates at 3. Without the macro -> redirect_cnt=0.
